// File: rtl/mul_share_arb_if.sv
// Multiply-request bus between the requesters (master side) and the
// shared multiplier responder (slave side).
//   req_en        per-requester request valid
//   req_in_1/2    operand A / B, requester i at bits [32i+31:32i]
//   gnt           one-hot grant, combinational in the request cycle
//   rsp_valid     one-hot, product for the indicated requester is valid
//   rsp_out       64-bit unsigned product (holds between results)
//   rsp_id        index of the requester owning rsp_out
//   conflict_cnt  saturating count of cycles with >= 2 requests
interface mul_share_arb_if #(
    parameter int NCLI = 3
);
    logic [NCLI-1:0]      req_en;
    logic [NCLI*32-1:0]   req_in_1;
    logic [NCLI*32-1:0]   req_in_2;
    logic [NCLI-1:0]      gnt;
    logic [NCLI-1:0]      rsp_valid;
    logic [63:0]          rsp_out;
    logic [1:0]           rsp_id;
    logic [15:0]          conflict_cnt;

    modport master (
        output req_en, req_in_1, req_in_2,
        input  gnt, rsp_valid, rsp_out, rsp_id, conflict_cnt
    );

    modport slave (
        input  req_en, req_in_1, req_in_2,
        output gnt, rsp_valid, rsp_out, rsp_id, conflict_cnt
    );
endinterface

// File: rtl/mul_share_arb.sv
// Shared pipelined 32x32 unsigned multiplier with an age-aware arbiter.
// Lowest index wins unless some requester has been denied MAX_WAIT
// consecutive cycles; promoted requesters then win (lowest index first).
// Results come back LAT cycles after the accept, in accept order.
//   clk    clock, rising edge
//   reset  asynchronous, active-high
//   bus    mul_share_arb_if slave port (requests, grant, response, stats)

// Per-requester age counter; flags the requester once it has waited
// MAX_WAIT consecutive denied cycles.
module mul_share_arb_age #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic gnt,
    output logic promo
);
    logic [3:0] wait_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wait_cnt <= '0;
        else if (!en || gnt)
            wait_cnt <= '0;
        else if (wait_cnt != 4'(MAX_WAIT))
            wait_cnt <= wait_cnt + 4'd1;
    end

    assign promo = en && (wait_cnt == 4'(MAX_WAIT));
endmodule

module mul_share_arb #(
    parameter int NCLI     = 3,
    parameter int LAT      = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic           clk,
    input  logic           reset,
    mul_share_arb_if.slave bus
);
    localparam int STAGES = LAT - 1;

    logic [NCLI-1:0] promo;
    logic [NCLI-1:0] gnt;
    logic            acc;
    logic [31:0]     a_sel, b_sel;
    logic [1:0]      id_sel;
    logic [15:0]     conflict_q;

    // Valid travels as the one-hot grant so the last stage is rsp_valid
    // directly, with no decode after the flops.
    logic [STAGES:0][NCLI-1:0] vld_pipe;
    logic [STAGES:0][1:0]      id_pipe;
    logic [63:0]               prod_last;

    genvar gi;
    generate
        for (gi = 0; gi < NCLI; gi++) begin : g_age
            mul_share_arb_age #(.MAX_WAIT(MAX_WAIT)) u_age (
                .clk   (clk),
                .reset (reset),
                .en    (bus.req_en[gi]),
                .gnt   (gnt[gi]),
                .promo (promo[gi])
            );
        end
    endgenerate

    // Scan from the top so the lowest qualifying index is written last.
    always_comb begin
        gnt = '0;
        if (|promo) begin
            for (int i = NCLI-1; i >= 0; i--)
                if (promo[i]) begin
                    gnt    = '0;
                    gnt[i] = 1'b1;
                end
        end else begin
            for (int i = NCLI-1; i >= 0; i--)
                if (bus.req_en[i]) begin
                    gnt    = '0;
                    gnt[i] = 1'b1;
                end
        end
    end

    assign bus.gnt = gnt;
    assign acc     = |gnt;

    // Grant is one-hot, so an AND-OR mux picks the winner's operands.
    always_comb begin
        a_sel  = '0;
        b_sel  = '0;
        id_sel = '0;
        for (int i = 0; i < NCLI; i++) begin
            a_sel = a_sel | (bus.req_in_1[i*32 +: 32] & {32{gnt[i]}});
            b_sel = b_sel | (bus.req_in_2[i*32 +: 32] & {32{gnt[i]}});
            if (gnt[i])
                id_sel = 2'(i);
        end
    end

    // Valid/id pipe; id only advances with a valid entry so the last
    // stage holds the id of the most recent result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            vld_pipe[0] <= gnt;
            if (acc)
                id_pipe[0] <= id_sel;
            for (int k = 1; k <= STAGES; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                if (|vld_pipe[k-1])
                    id_pipe[k] <= id_pipe[k-1];
            end
        end
    end

    generate
        if (LAT == 1) begin : g_lat1
            logic [63:0] prod_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    prod_q <= '0;
                else if (acc)
                    prod_q <= {32'd0, a_sel} * {32'd0, b_sel};
            end

            assign prod_last = prod_q;
        end else begin : g_latn
            logic [31:0] a_q, b_q;
            logic [63:0] prod_pipe [STAGES:1];

            // Stage 0 holds operands; the multiply sits between stage 0
            // and stage 1, later stages only delay the product.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    a_q <= '0;
                    b_q <= '0;
                    for (int k = 1; k <= STAGES; k++)
                        prod_pipe[k] <= '0;
                end else begin
                    if (acc) begin
                        a_q <= a_sel;
                        b_q <= b_sel;
                    end
                    if (|vld_pipe[0])
                        prod_pipe[1] <= {32'd0, a_q} * {32'd0, b_q};
                    for (int k = 2; k <= STAGES; k++)
                        if (|vld_pipe[k-1])
                            prod_pipe[k] <= prod_pipe[k-1];
                end
            end

            assign prod_last = prod_pipe[STAGES];
        end
    endgenerate

    assign bus.rsp_valid = vld_pipe[STAGES];
    assign bus.rsp_id    = id_pipe[STAGES];
    assign bus.rsp_out   = prod_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            conflict_q <= '0;
        else if (($countones(bus.req_en) >= 2) && (conflict_q != 16'hFFFF))
            conflict_q <= conflict_q + 16'd1;
    end

    assign bus.conflict_cnt = conflict_q;
endmodule
